// File: rtl/guvm_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : guvm_resp_pkg
// Description : Shared constants, record types and LFSR step for the
//               memory-side responder.
// Revision    : 1.0 - initial release
// ============================================================================
package guvm_resp_pkg;

  localparam logic [31:0] DEFAULT_RDATA = 32'h0000_0013;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam int          BUS_AW        = 32;
  localparam int          BUS_DW        = 32;

  typedef struct packed {
    logic [BUS_AW-1:0]   addr;
    logic [BUS_DW/8-1:0] be;
    logic [BUS_DW-1:0]   data;
  } cap_entry_t;

  typedef struct packed {
    logic              valid;
    logic [BUS_DW-1:0] data;
  } pipe_stage_t;

  // Fibonacci form, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/guvm_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : guvm_sync_fifo
// Description : Single-clock FIFO, DEPTH a power of two (>= 2); full/empty
//               from an extra pointer wrap bit; head is zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module guvm_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic         empty, full, do_push, do_pop;

  // A pop from an empty FIFO is ignored, so a same-cycle push never bypasses.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    do_pop   = pop_i & ~empty;
    do_push  = push_i & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
  end

  assign data_o  = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign full_o  = full;
  assign empty_o = empty;

endmodule
`default_nettype wire

// File: rtl/guvm_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : guvm_mem_responder
// Description : Memory-side req/gnt/rvalid responder with fixed read latency,
//               stimulus-fed read data and store capture. Optional random
//               grant stalls via macro GUVM_RESP_RANDSTALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module guvm_mem_responder
  import guvm_resp_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STIM_DEPTH      = 16,
  parameter int CAP_DEPTH       = 8,
  parameter bit STALL_ON_EMPTY  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [AW-1:0]   addr_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  output logic            gnt_o,
  output logic            rvalid_o,
  output logic [DW-1:0]   rdata_o,
  input  logic            stim_valid_i,
  input  logic [DW-1:0]   stim_data_i,
  output logic            stim_ready_o,
  output logic            cap_valid_o,
  output logic [AW-1:0]   cap_addr_o,
  output logic [DW/8-1:0] cap_be_o,
  output logic [DW-1:0]   cap_data_o,
  input  logic            cap_ready_i,
  input  logic [3:0]      stall_thr_i,
  output logic            underflow_o,
  output logic [3:0]      outstanding_o
);

  localparam int BW = DW / 8;
  localparam int CW = AW + BW + DW;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
  } stage_t;

  if (LATENCY < 1 || LATENCY > 8 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY)
  begin : g_param_check
    $error("guvm_mem_responder: LATENCY must be 1..8 and MAX_OUTSTANDING 1..LATENCY");
  end

  logic                  stim_empty, stim_full, stim_pop;
  logic [DW-1:0]         stim_head;
  logic                  cap_empty, cap_full, cap_push;
  logic [CW-1:0]         cap_head;
  logic                  rand_stall, accept;
  stage_t [LATENCY-1:0]  pipe_q, pipe_d;
  logic [3:0]            outstanding_q, outstanding_d;
  logic                  underflow_q, underflow_d;

`ifdef GUVM_RESP_RANDSTALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign rand_stall = (lfsr_q[3:0] < stall_thr_i);
`else
  logic unused_stall_thr;
  assign unused_stall_thr = ^stall_thr_i;
  assign rand_stall       = 1'b0;
`endif

  assign gnt_o = req_i & ~rst_i
               & (outstanding_q < 4'(MAX_OUTSTANDING))
               & ~(we_i & cap_full)
               & ~(~we_i & stim_empty & STALL_ON_EMPTY)
               & ~rand_stall;

  assign accept   = gnt_o;
  assign stim_pop = accept & ~we_i;
  assign cap_push = accept & we_i;

  guvm_sync_fifo #(.W(DW), .DEPTH(STIM_DEPTH)) u_stim_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (stim_valid_i),
    .data_i  (stim_data_i),
    .pop_i   (stim_pop),
    .data_o  (stim_head),
    .full_o  (stim_full),
    .empty_o (stim_empty)
  );

  guvm_sync_fifo #(.W(CW), .DEPTH(CAP_DEPTH)) u_cap_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cap_push),
    .data_i  ({addr_i, be_i, wdata_i}),
    .pop_i   (cap_ready_i),
    .data_o  (cap_head),
    .full_o  (cap_full),
    .empty_o (cap_empty)
  );

  // Stage 0 loads the response; idle slots carry zero data so rdata_o stays quiet.
  always_comb begin
    pipe_d          = '0;
    pipe_d[0].valid = accept;
    if (accept & ~we_i)
      pipe_d[0].data = stim_empty ? DW'(DEFAULT_RDATA) : stim_head;
    for (int i = 1; i < LATENCY; i++)
      pipe_d[i] = pipe_q[i-1];

    underflow_d   = underflow_q | (accept & ~we_i & stim_empty);
    outstanding_d = outstanding_q;
    case ({accept, pipe_q[LATENCY-1].valid})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q        <= '0;
      outstanding_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      pipe_q        <= pipe_d;
      outstanding_q <= outstanding_d;
      underflow_q   <= underflow_d;
    end
  end

  assign rvalid_o                           = pipe_q[LATENCY-1].valid;
  assign rdata_o                            = pipe_q[LATENCY-1].data;
  assign stim_ready_o                       = ~stim_full;
  assign cap_valid_o                        = ~cap_empty;
  assign {cap_addr_o, cap_be_o, cap_data_o} = cap_head;
  assign underflow_o                        = underflow_q;
  assign outstanding_o                      = outstanding_q;

endmodule
`default_nettype wire
